serial_tx: RTL
==============

# serial_tx

UART transmitter and the companion to the `serial` receiver. It accepts bytes from the host logic into a small internal FIFO and serialises them as 8N1 frames on `tx`, LSB first. The bit period matches the receiver's period for the same `RCONST`, so the two blocks interoperate and can be looped back. It sits between the system logic and the board's UART TX pin.

## Interface
- `RCONST`, default 25: the bit period is `RCONST+1` clocks. Any value ≥ 2 is legal.
- `FIFO_AW`, default 4: FIFO depth is `2**FIFO_AW` (16).
- `clk`  in  1: single clock. Everything is synchronous to `posedge clk`.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tx_byte`  in  8: byte to send.
- `tx_wr`  in  1: write strobe. The byte is accepted on an edge where `tx_wr && !tx_full`.
- `tx_full`  out  1: FIFO full. Combinational from the registered count.
- `tx_busy`  out  1: high while the FIFO is non-empty or a frame is in progress.
- `fifo_level`  out  FIFO_AW+1: number of bytes queued. The byte currently being shifted is not counted.
- `tx`  out  1: serial line, registered, idles high.

## Operation
- The FIFO write side accepts on `tx_wr && !tx_full`.
  - A write while full is dropped silently; no state changes.
  - A simultaneous accepted write and FSM pop leaves `fifo_level` unchanged.
  - `tx_full` is evaluated from the pre-edge count, so a write in the same cycle as a pop while full is still rejected.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, set `tx`<=0, clear the baud counter and go to START.
  - **START:** hold for `RCONST+1` clocks. Then `tx`<=shift[0], bit index <= 0, go to DATA.
  - **DATA:** every `RCONST+1` clocks, shift right and drive the next bit. After bit 7 has been held a full period, `tx`<=1 and go to STOP.
  - **STOP:** hold `tx`=1 for `RCONST+1` clocks. At the end of the period:
    - If the FIFO is non-empty, pop, `tx`<=0 and go to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter: 16 bits, counts 0..`RCONST` and wraps to 0. It is held at 0 in IDLE.
- Bit index: 3 bits. It wraps from 7 only through the DATA→STOP transition.
- `tx_byte` is captured at the accept edge. Later changes on the input do not affect queued data.
- Reset (asynchronous, any time, including mid-frame):
  - Forces `tx`=1, state IDLE, counter 0, FIFO empty.
  - Outputs: `fifo_level`=0, `tx_full`=0, `tx_busy`=0.
  - A partial frame is abandoned, not completed.

## Timing
- Write accepted at edge k: `fifo_level` updates after k. The FSM pops at k+1 and `tx` falls after k+1, so the start bit appears one clock after accept.
- Frame length: exactly 10·(`RCONST+1`) clocks (start, 8 data, stop). With `RCONST`=25 that is 26 clocks per bit and 260 per frame.
- Back-to-back frames: start bit n+1 begins on the clock immediately after stop bit n ends.
- `tx_busy` falls on the same edge the FSM enters IDLE with the FIFO empty.
- No combinational path from `tx_wr` to `tx`. `tx_full` depends only on registered state.

## Structure
- Package `serial_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Default `RCONST` constant, shared with the receiver.
  - Frame constants: `DATA_BITS`=8, `STOP_BITS`=1.
- Sub-module `serial_fifo`: synchronous single-clock FIFO with parameters `WIDTH`=8 and `AW`.
  - Ports: `wr`, `din`, `rd`, `dout` (show-ahead), `full`, `empty`, `level`.
  - Same clock and reset as the top.
- Top-level `serial_tx`: FSM, baud counter, shift register, `tx` register.

## Test plan
- **Reset idle:** hold `rst_n`=0, then release → `tx`=1, `tx_busy`=0, `fifo_level`=0 for 100 clocks with no writes.
- **Single byte:** write 0xA5 with `RCONST`=25 → `tx` low one clock after accept.
  - Sampled at the centre of each 26-clock bit: 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` drops exactly 260 clocks after `tx` first fell.
- **Burst and full:** write 17 bytes 0x00..0x10 on consecutive clocks.
  - The first byte is popped, and 16 further bytes are accepted.
  - The 18th write, 0x11, is attempted while full → dropped, with `tx_full`=1 observed.
  - Output is 17 contiguous frames with no idle gap, in order.
- **Loopback:** connect `tx` to the `serial` receiver with the same `RCONST` and send 0x00, 0xFF, 0x55, 0x3C → receiver `rx_byte` matches each byte in order, with one `rbyte_ready` pulse per frame.
- **Reset mid-frame:** assert `rst_n` during data bit 3 of 0x81 with 2 bytes queued.
  - `tx`=1 immediately, and `fifo_level`=0.
  - After release, the line stays idle and no frame is emitted.
- **Write/pop collision:** with the FIFO at level 3, assert `tx_wr` on the stop-bit end edge → the pop and the write coincide and `fifo_level` stays 3.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and receiver pair:
// FSM state encoding, default bit-period constant and frame geometry.
package serial_pkg;

    // Transmitter frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Default bit period is RCONST+1 clocks; the receiver uses the same value
    localparam int RCONST_DEFAULT = 25;

    // Width of the baud counter
    localparam int BAUD_CW = 16;

    // Frame geometry: 8 data bits, 1 stop bit (8N1)
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/serial_fifo.sv
// Single-clock show-ahead FIFO used to queue bytes ahead of the transmitter.
// A write while full and a read while empty are ignored.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    // Advance pointers and occupancy; a simultaneous push and pop keeps the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared to empty on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter: bytes are queued in a small FIFO and sent as 8N1 frames,
// LSB first, with a bit period of RCONST+1 clocks. Consecutive queued bytes
// go out back to back with no idle gap between stop and next start bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int RCONST  = RCONST_DEFAULT,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_byte,
    input  logic             tx_wr,
    output logic             tx_full,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             tx
);

    localparam logic [BAUD_CW-1:0] BAUD_LAST = BAUD_CW'(RCONST);
    localparam logic [2:0]         LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]         LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t          state_q, state_d;
    logic [BAUD_CW-1:0] baud_q,  baud_d;
    logic [2:0]         bit_q,   bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q,    tx_d;

    logic               pop;
    logic [7:0]         fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               baud_done;

    serial_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (tx_wr),
        .din   (tx_byte),
        .rd    (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    assign tx      = tx_q;
    assign tx_full = fifo_full;
    assign tx_busy = !fifo_empty || (state_q != IDLE);

    // Frame sequencing: start bit, eight data bits from the shifter, stop bits,
    // then either chain straight into the next queued byte or return to idle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == LAST_DATA) begin
                        tx_d    = 1'b1;
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_dout;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Transmitter registers; reset abandons any partial frame and idles the line high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
